pia_multi: RTL
==============

// Module: pia_multi
// PURPOSE
//  Parametrised successor to the MC6820 PIA. Provides NUM_PORTS peripheral ports of PORT_WIDTH bits.
//  Each port has its own data direction, output, and control registers, C1/C2 control lines and IRQ.
//  Sits on the same 8-bit CPU bus and E-clock domain as the existing PIA; drop-in for 1..8-port systems.
// PARAMETERS
//  NUM_PORTS      2      number of peripheral ports (1..8)
//  PORT_WIDTH     8      bits per port (1..8); unused data-bus bits read 0
//  WR_STROBE_MASK 2'b10  bit p=1: port p C2 handshake/pulse triggered by data write, else by data read
// PORTS
//  enable   in   1               E clock; all state updates on rising edge
//  reset    in   1               asynchronous, active-high reset
//  cs       in   3               chip select; selected when cs==3'b011
//  rs       in   AW              AW=$clog2(NUM_PORTS)+1; rs[AW-1:1]=port index, rs[0]=0 data/DDR, 1 control
//  rw       in   1               1=read, 0=write
//  di       in   8               CPU write data
//  do       out  8               CPU read data (combinational from registered state)
//  pi       in   NUM_PORTS*PW    port pin inputs, port p at [p*PW +: PW]
//  po       out  NUM_PORTS*PW    output registers
//  po_oe    out  NUM_PORTS*PW    per-bit output enable (=DDR)
//  c1       in   NUM_PORTS       C1 interrupt inputs
//  c2i      in   NUM_PORTS       C2 inputs
//  c2o      out  NUM_PORTS       C2 outputs
//  c2_oe    out  NUM_PORTS       1 when CR[5]=1 (C2 is output)
//  irq_n    out  NUM_PORTS       active-low per-port interrupt
// BEHAVIOUR
//  Reset (async): OR, DDR, CR = 0. po=0, po_oe=0, c2o=1, c2_oe=0, irq_n=all 1, c1/c2 edge history = 0.
//  Access: when selected, act on the rising edge of enable. Port index >= NUM_PORTS: reads 0, writes ignored.
//  Control register CR[p]:
//   b0 C1 IRQ enable
//   b1 C1 active edge (1 rising, 0 falling)
//   b2 1=data reg at rs[0]=0, 0=DDR
//   b5:3 C2 control
//   b7 IRQ1 flag (read-only)
//   b6 IRQ2 flag (read-only)
//   Writes to CR update b5:0 only.
//  C2 modes:
//   b5=0 input: b4 active edge (1 rising), b3 IRQ2 enable
//   b5=1,b4=1 manual: c2o=b3
//   b5=1,b4=0,b3=0 handshake: c2o goes low the cycle after a trigger access; returns high on C1 active edge
//   b5=1,b4=0,b3=1 pulse: c2o low for exactly one enable cycle after a trigger access
//   Trigger access: data-reg write if WR_STROBE_MASK[p], else data-reg read. DDR accesses never trigger.
//  Edge detection:
//   c1/c2i sampled each rising edge; edge = sampled value differs from previous sample in the active direction.
//   IRQ1 sets on a C1 active edge. IRQ2 sets on a C2 active edge only while b5=0.
//   Flags set regardless of enable bits.
//  Flag clear: both flags of port p clear on a selected data-register read of p (CR b2=1).
//   Simultaneous set and clear in the same cycle: set wins (flag stays 1).
//  irq_n[p] = ~((b7&b0) | (b6&b3&~b5)). Registered path; asserts one cycle after the edge is sampled.
//  Data read: bit i = DDR[i] ? OR[i] : pi[i]. DDR/CR reads return register contents, zero-extended to 8.
//  Writes to OR/DDR take the low PORT_WIDTH bits of di. po and po_oe update the same edge.
//  Changing CR b5:3 mid-handshake: c2o immediately follows the new mode; pending pulse/handshake is cancelled.
// CONFIGURATION
//  PIA_INPUT_SYNC_EN defined:
//   pi, c1 and c2i pass through 2-flop synchronisers (reset 0) before use.
//   Adds 2 cycles to edge->flag and pin->read latency.
//  Not defined: inputs sampled directly (single history flop for edge detection only).
// TESTING
//  1 Reset pulse mid-run -> irq_n=11, c2o=11, po=0, po_oe=0; read CR0 -> 8'h00.
//  2 CR0<=8'h05; c1[0] 1->0 -> CR0 reads 8'h85, irq_n[0]=0; read data0 -> irq_n[0]=1, CR0 reads 8'h05.
//  3 CR0<=8'h00, DDR0<=8'hF0, CR0<=8'h04, data0<=8'hA5, pi0=8'h3C -> po0=8'hA5, po_oe0=8'hF0, read data0=8'hAC.
//  4 CR1<=8'h2C; write data1 -> c2o[1] low exactly one cycle, then high; a read of data1 does not pulse.
//  5 CR0<=8'h26; read data0 -> c2o[0] low and held; c1[0] 0->1 -> c2o[0] high next cycle.
//  6 c1[0] active edge in same cycle as data0 read -> CR0 b7 stays 1; with PIA_INPUT_SYNC_EN, flag appears 2 cycles later than without.

Source files
------------

// File: rtl/pia_multi.sv
// pia_multi: MC6820-style PIA with NUM_PORTS ports of PORT_WIDTH bits on an 8-bit bus clocked by E.
// Optional feature: define PIA_INPUT_SYNC_EN to pass pi/c1/c2i through 2-flop synchronisers.
module pia_multi #(
  parameter int         NUM_PORTS      = 2,
  parameter int         PORT_WIDTH     = 8,
  parameter logic [7:0] WR_STROBE_MASK = 8'b0000_0010,
  localparam int        AW             = $clog2(NUM_PORTS) + 1,
  localparam int        PW             = PORT_WIDTH
) (
  input  logic                    enable,
  input  logic                    reset,
  input  logic [2:0]              cs,
  input  logic [AW-1:0]           rs,
  input  logic                    rw,
  input  logic [7:0]              di,
  output logic [7:0]              dout,
  input  logic [NUM_PORTS*PW-1:0] pi,
  output logic [NUM_PORTS*PW-1:0] po,
  output logic [NUM_PORTS*PW-1:0] po_oe,
  input  logic [NUM_PORTS-1:0]    c1,
  input  logic [NUM_PORTS-1:0]    c2i,
  output logic [NUM_PORTS-1:0]    c2o,
  output logic [NUM_PORTS-1:0]    c2_oe,
  output logic [NUM_PORTS-1:0]    irq_n
);

  logic [NUM_PORTS*PW-1:0] pi_use;
  logic [NUM_PORTS-1:0]    c1_use, c2_use;
  logic                    selected;
  logic [AW-1:0]           port_sel;
  logic [7:0]              rd_val [NUM_PORTS];

`ifdef PIA_INPUT_SYNC_EN
  logic [NUM_PORTS*PW-1:0] pi_s1, pi_s2;
  logic [NUM_PORTS-1:0]    c1_s1, c1_s2, c2_s1, c2_s2;

  always_ff @(posedge enable or posedge reset) begin
    if (reset) begin
      pi_s1 <= '0;
      pi_s2 <= '0;
      c1_s1 <= '0;
      c1_s2 <= '0;
      c2_s1 <= '0;
      c2_s2 <= '0;
    end else begin
      pi_s1 <= pi;
      pi_s2 <= pi_s1;
      c1_s1 <= c1;
      c1_s2 <= c1_s1;
      c2_s1 <= c2i;
      c2_s2 <= c2_s1;
    end
  end

  assign pi_use = pi_s2;
  assign c1_use = c1_s2;
  assign c2_use = c2_s2;
`else
  assign pi_use = pi;
  assign c1_use = c1;
  assign c2_use = c2i;
`endif

  assign selected = (cs == 3'b011);
  assign port_sel = rs >> 1;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam logic [AW-1:0] PIDX = AW'(p);

    logic [PW-1:0] or_q, ddr_q, pin_val, data_val;
    logic [5:0]    cr_q;
    logic          irq1_q, irq2_q, c1_prev_q, c2_prev_q, c2_low_q;
    logic          acc, data_sel, ddr_sel, ctl_sel, trig, rd_clear, mode_change;
    logic          c1_edge, c2_edge, hs_mode, pulse_mode;

    assign acc         = selected && (port_sel == PIDX);
    assign data_sel    = acc && !rs[0] && cr_q[2];
    assign ddr_sel     = acc && !rs[0] && !cr_q[2];
    assign ctl_sel     = acc && rs[0];
    assign trig        = data_sel && (WR_STROBE_MASK[p] ? !rw : rw);
    assign rd_clear    = data_sel && rw;
    assign mode_change = ctl_sel && !rw && (di[5:3] != cr_q[5:3]);
    assign hs_mode     = cr_q[5] && !cr_q[4] && !cr_q[3];
    assign pulse_mode  = cr_q[5] && !cr_q[4] && cr_q[3];
    assign c1_edge     = cr_q[1] ? (c1_use[p] && !c1_prev_q) : (!c1_use[p] && c1_prev_q);
    assign c2_edge     = cr_q[4] ? (c2_use[p] && !c2_prev_q) : (!c2_use[p] && c2_prev_q);

    // c2_low_q is the pending pulse/handshake; a mode change drops it so c2o tracks the new mode.
    always_ff @(posedge enable or posedge reset) begin
      if (reset) begin
        or_q      <= '0;
        ddr_q     <= '0;
        cr_q      <= '0;
        irq1_q    <= 1'b0;
        irq2_q    <= 1'b0;
        c1_prev_q <= 1'b0;
        c2_prev_q <= 1'b0;
        c2_low_q  <= 1'b0;
      end else begin
        c1_prev_q <= c1_use[p];
        c2_prev_q <= c2_use[p];
        if (data_sel && !rw) or_q  <= di[PW-1:0];
        if (ddr_sel && !rw)  ddr_q <= di[PW-1:0];
        if (ctl_sel && !rw)  cr_q  <= di[5:0];
        irq1_q <= c1_edge || (irq1_q && !rd_clear);
        irq2_q <= (c2_edge && !cr_q[5]) || (irq2_q && !rd_clear);
        if (mode_change)     c2_low_q <= 1'b0;
        else if (hs_mode)    c2_low_q <= trig ? 1'b1 : (c1_edge ? 1'b0 : c2_low_q);
        else if (pulse_mode) c2_low_q <= trig;
        else                 c2_low_q <= 1'b0;
      end
    end

    assign pin_val  = pi_use[p*PW +: PW];
    assign data_val = (ddr_q & or_q) | (~ddr_q & pin_val);

    assign po[p*PW +: PW]    = or_q;
    assign po_oe[p*PW +: PW] = ddr_q;
    assign c2_oe[p]          = cr_q[5];
    assign c2o[p]            = cr_q[5] ? (cr_q[4] ? cr_q[3] : !c2_low_q) : 1'b1;
    assign irq_n[p]          = !((irq1_q && cr_q[0]) || (irq2_q && cr_q[3] && !cr_q[5]));
    assign rd_val[p]         = rs[0] ? {irq1_q, irq2_q, cr_q}
                                     : (cr_q[2] ? 8'(data_val) : 8'(ddr_q));
  end

  // Unmatched port indices fall through to zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (selected && rw && (port_sel == AW'(i))) dout = rd_val[i];
    end
  end

endmodule
